// File: rtl/pcm_pkg.sv
// pcm_pkg: shared constants, FSM state type and Q2.30 -> PCM16 conversion
// for the PCM output streamer.
package pcm_pkg;

    localparam int PCM_MAX     = 32767;
    localparam int PCM_MIN     = -32768;
    localparam int Q2_30_ROUND = 16384;
    localparam int Q2_30_SHIFT = 15;

    typedef enum logic {
        FILL = 1'b0,
        PLAY = 1'b1
    } pcm_state_e;

    // Round-half-up, arithmetic shift, then clamp to the 16-bit range.
    // The sum is kept at 33 bits so large positive inputs cannot wrap.
    function automatic logic [15:0] q2_30_to_pcm(input logic [31:0] x);
        logic signed [32:0] sum;
        logic signed [32:0] shr;
        logic [15:0]        q;
        sum = $signed({x[31], x}) + 33'(Q2_30_ROUND);
        shr = sum >>> Q2_30_SHIFT;
        if (shr > 33'(PCM_MAX)) begin
            q = 16'(PCM_MAX);
        end else if (shr < 33'(PCM_MIN)) begin
            q = 16'(PCM_MIN);
        end else begin
            q = shr[15:0];
        end
        return q;
    endfunction

endpackage

// File: rtl/pcm_fifo.sv
// pcm_fifo: synchronous first-word-fall-through FIFO with registered read.
// Ports: clk, rst (sync, high), wr_en_i/wr_data_i, rd_en_i, rd_data_o (head),
// count_o (occupancy), empty_o.
import pcm_pkg::*;

module pcm_fifo #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] rdata_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, wr_en_i};
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, rd_en_i};
        count_d  = count_q + {{AW{1'b0}}, wr_en_i}
                           - {{AW{1'b0}}, rd_en_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Read the next head address each cycle; bypass the write data when it
    // lands on that address so the head is correct one cycle after a write.
    always_ff @(posedge clk) begin
        if (wr_en_i && (wr_ptr_q == rd_ptr_d)) begin
            rdata_q <= wr_data_i;
        end else begin
            rdata_q <= mem_q[rd_ptr_d];
        end
    end

    assign rd_data_o = rdata_q;
    assign count_o   = count_q;
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/pcm_output_streamer.sv
// pcm_output_streamer: converts Q2.30 samples to PCM16, buffers them, and
// plays one sample per CLK_DIV clocks after a prefill. Ports: clk, rst,
// x_in/x_valid_in/x_ready_out (input stream), pcm_out/pcm_valid_out (tick
// output), fifo_count_out, underrun_count_out, overflow_out; with macro
// PCM_PWM_EN also audio_pwm_out (8-bit carrier PWM of pcm_out).
import pcm_pkg::*;

module pcm_output_streamer #(
    parameter int CLK_DIV    = 2268,
    parameter int FIFO_DEPTH = 2048,
    parameter int PREFILL    = 1152
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x_in,
    input  logic        x_valid_in,
    output logic        x_ready_out,
    output logic [15:0] pcm_out,
    output logic        pcm_valid_out,
    output logic [11:0] fifo_count_out,
    output logic [15:0] underrun_count_out,
    output logic        overflow_out
`ifdef PCM_PWM_EN
    ,
    output logic        audio_pwm_out
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [15:0]   stage_q, stage_d;
    logic          stage_valid_q, stage_valid_d;
    logic [CW-1:0] count;
    logic          empty;
    logic [15:0]   head;
    logic          pop;
    logic [TW-1:0] tick_q, tick_d;
    logic          tick;
    pcm_state_e    state_q, state_d;
    logic [15:0]   pcm_q, pcm_d;
    logic [15:0]   urun_q, urun_d;
    logic          ovf_q, ovf_d;
    logic          accept;

    // The staged sample is counted so the FIFO can never be overcommitted.
    assign x_ready_out = (count + CW'(stage_valid_q)) < CW'(FIFO_DEPTH);
    assign accept      = x_valid_in && x_ready_out;

    assign tick   = !rst && (tick_q == TW'(CLK_DIV - 1));
    assign tick_d = (tick_q == TW'(CLK_DIV - 1)) ? '0 : tick_q + 1'b1;

    always_comb begin
        stage_d       = q2_30_to_pcm(x_in);
        stage_valid_d = accept;
        ovf_d         = ovf_q | (x_valid_in & ~x_ready_out);
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        pcm_d   = pcm_q;
        urun_d  = urun_q;
        case (state_q)
            FILL: begin
                if (tick) begin
                    pcm_d = '0;
                end
                if (count >= CW'(PREFILL)) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (tick && !empty) begin
                    pop   = 1'b1;
                    pcm_d = head;
                end else if (tick) begin
                    pcm_d   = '0;
                    state_d = FILL;
                    if (urun_q != 16'hFFFF) begin
                        urun_d = urun_q + 16'd1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q       <= '0;
            stage_valid_q <= 1'b0;
            tick_q        <= '0;
            state_q       <= FILL;
            pcm_q         <= '0;
            urun_q        <= '0;
            ovf_q         <= 1'b0;
        end else begin
            stage_q       <= stage_d;
            stage_valid_q <= stage_valid_d;
            tick_q        <= tick_d;
            state_q       <= state_d;
            pcm_q         <= pcm_d;
            urun_q        <= urun_d;
            ovf_q         <= ovf_d;
        end
    end

    pcm_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (stage_valid_q),
        .wr_data_i (stage_q),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .count_o   (count),
        .empty_o   (empty)
    );

    // The tick-cycle value is presented immediately and held afterwards.
    assign pcm_out            = pcm_d;
    assign pcm_valid_out      = tick;
    assign fifo_count_out     = 12'(count);
    assign underrun_count_out = urun_q;
    assign overflow_out       = ovf_q;

`ifdef PCM_PWM_EN
    logic [7:0] carrier_q;
    logic [7:0] level;

    // Adding 32768 to a 16-bit signed value only flips the sign bit.
    assign level = pcm_out[15:8] ^ 8'h80;

    always_ff @(posedge clk) begin
        if (rst) begin
            carrier_q <= '0;
        end else begin
            carrier_q <= carrier_q + 8'd1;
        end
    end

    assign audio_pwm_out = !rst && (carrier_q < level);
`endif

endmodule

// File: doc/pcm_output_streamer.md
PCM_OUTPUT_STREAMER -- requirements
Module: pcm_output_streamer

Interface
REQ-001 Parameter CLK_DIV, default 2268: clk cycles per output sample tick (100 MHz / 44.1 kHz).
REQ-002 Parameter FIFO_DEPTH, default 2048: PCM FIFO entries, power of two, at least 1152.
REQ-003 Parameter PREFILL, default 1152: FIFO occupancy required to leave FILL.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port x_in, input, 32 bits: signed Q2_30 synthesized sample from subband synthesis.
REQ-007 Port x_valid_in, input, 1 bit: x_in is valid this cycle.
REQ-008 Port x_ready_out, output, 1 bit: the block can accept a sample this cycle.
REQ-009 Port pcm_out, output, 16 bits: signed PCM sample, held between ticks.
REQ-010 Port pcm_valid_out, output, 1 bit: one-cycle pulse per sample tick.
REQ-011 Port fifo_count_out, output, 12 bits: current FIFO occupancy.
REQ-012 Port underrun_count_out, output, 16 bits: number of underrun ticks, saturating.
REQ-013 Port overflow_out, output, 1 bit: sticky flag, set when a valid sample is dropped.

Function
REQ-014 Conversion: add 2^14 to x_in, arithmetic shift right by 15, saturate to [-32768, 32767].
REQ-015 The conversion is registered as one pipeline stage, giving a push-to-FIFO-write latency of 1 cycle.
REQ-016 x_ready_out = (fifo_count + stage_valid) < FIFO_DEPTH, evaluated combinationally.
REQ-017 If x_valid_in is high while x_ready_out is low, the sample is dropped and overflow_out is set.
REQ-018 A tick counter runs 0 to CLK_DIV-1 and wraps; a tick occurs in the cycle the counter equals CLK_DIV-1.
REQ-019 The counter runs continuously from reset, independent of FIFO state.
REQ-020 State machine has two states, FILL and PLAY.
REQ-021 FILL: each tick drives pcm_out=0 and pulses pcm_valid_out; no pop.
REQ-022 FILL moves to PLAY when fifo_count >= PREFILL.
REQ-023 PLAY, tick with FIFO non-empty: pop one sample to pcm_out and pulse pcm_valid_out in the same cycle.
REQ-024 PLAY, tick with FIFO empty: pcm_out=0, pcm_valid_out pulses, underrun_count increments, state returns to FILL.
REQ-025 A FIFO write and a pop in the same cycle are both performed; occupancy is unchanged.
REQ-026 FIFO read and write pointers wrap modulo FIFO_DEPTH.
REQ-027 underrun_count_out saturates at 16'hFFFF.

Reset
REQ-028 On rst: state=FILL, FIFO empty, tick counter=0, stage_valid=0.
REQ-029 On rst: pcm_out=0, pcm_valid_out=0, underrun_count_out=0, overflow_out=0.
REQ-030 rst asserted mid-stream discards all buffered samples; FIFO contents are not preserved.

Configuration
REQ-031 Macro PCM_PWM_EN defined adds output port audio_pwm_out (1 bit) and a free-running 8-bit carrier counter.
REQ-032 With PCM_PWM_EN, audio_pwm_out is high while carrier < (pcm_out + 32768)[15:8]; it is 0 in reset.
REQ-033 Without PCM_PWM_EN, the port and the carrier logic are absent; all other behaviour is identical.

Structure
REQ-034 Package pcm_pkg holds the constants PCM_MAX, PCM_MIN, Q2_30_ROUND (2^14), Q2_30_SHIFT (15), and the state enum type {FILL, PLAY}.
REQ-035 One sub-module, pcm_fifo: synchronous FIFO, 16 bits wide by FIFO_DEPTH deep, BRAM-inferable, with first-word-fall-through read.

Verification
REQ-036 Saturation and rounding: input 32'h4000_0000 -> 32767; 32'hC000_0000 -> -32768; 32'h0000_4000 -> 1; 32'h0000_3FFF -> 0.
REQ-037 Prefill: push 1151 samples -> only zero samples are emitted; push 1 more -> the next tick outputs sample #0, in FIFO order.
REQ-038 Tick timing: with CLK_DIV=10, pcm_valid_out pulses exactly every 10 cycles, starting at cycle 9 after reset release.
REQ-039 Underrun: enter PLAY with 1152 samples, stop input -> tick 1153 outputs 0, underrun_count_out=1, state=FILL.
REQ-040 Overflow: with FIFO_DEPTH=2048 and no ticks, push 2050 samples -> x_ready_out low at occupancy 2048, overflow_out=1, fifo_count_out=2048.
REQ-041 Reset mid-stream: assert rst at occupancy 500 -> fifo_count_out=0 and all outputs at reset values on the next cycle.
